// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply / restoring-divide unit for the execute stage.
// Holds the upstream pipeline with stall_out while an operation is in flight.
module ex_muldiv_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_top,
  input  logic [WIDTH-1:0] operand_bot,
  input  logic             flush,
  output logic             stall_out,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  // Multiplier shifting right (MUL) or dividend shifting out / quotient shifting in (DIV)
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] acc_step_s;
  logic [WIDTH+1:0]   rem_shift_s;
  logic [WIDTH+1:0]   rem_diff_s;
  logic               rem_ge_s;
  logic [WIDTH:0]     rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;

  // One iteration of shift-add multiply and restoring divide.
  // The partial remainder stays below the divisor, so the sign of the
  // (W+2)-bit trial difference is a valid "fits" test.
  always_comb begin
    acc_step_s  = acc_q + (shreg_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    rem_shift_s = {rem_q, shreg_q[WIDTH-1]};
    rem_diff_s  = rem_shift_s - {2'b00, divisor_q};
    rem_ge_s    = ~rem_diff_s[WIDTH+1];
    if (rem_ge_s) begin
      rem_step_s = rem_diff_s[WIDTH:0];
    end else begin
      rem_step_s = rem_shift_s[WIDTH:0];
    end
    quo_step_s  = {shreg_q[WIDTH-2:0], rem_ge_s};
  end

  // Next-state, datapath-load and result-capture logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d      = op;
          cnt_d     = CNT_LAST;
          mcand_d   = {{WIDTH{1'b0}}, operand_top};
          shreg_d   = op ? operand_top : operand_bot;
          divisor_d = operand_bot;
          acc_d     = {(2*WIDTH){1'b0}};
          rem_d     = {(WIDTH+1){1'b0}};
          if (op && (operand_bot == {WIDTH{1'b0}})) begin
            state_d  = DONE;
            res_hi_d = operand_top;
            res_lo_d = {WIDTH{1'b1}};
            dz_d     = 1'b1;
          end else begin
            state_d  = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (op_q) begin
            rem_d   = rem_step_s;
            shreg_d = quo_step_s;
          end else begin
            acc_d   = acc_step_s;
            mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = DONE;
            dz_d    = 1'b0;
            if (op_q) begin
              res_hi_d = rem_step_s[WIDTH-1:0];
              res_lo_d = quo_step_s;
            end else begin
              res_hi_d = acc_step_s[2*WIDTH-1:WIDTH];
              res_lo_d = acc_step_s[WIDTH-1:0];
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      op_q      <= 1'b0;
      mcand_q   <= {(2*WIDTH){1'b0}};
      shreg_q   <= {WIDTH{1'b0}};
      divisor_q <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      rem_q     <= {(WIDTH+1){1'b0}};
      res_hi_q  <= {WIDTH{1'b0}};
      res_lo_q  <= {WIDTH{1'b0}};
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      dz_q      <= dz_d;
    end
  end

  // Stall is combinational so upstream freezes in the very cycle start is accepted.
  assign stall_out = (state_q == RUN) | ((state_q == IDLE) & start & ~flush);
  assign done      = (state_q == DONE);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: transaction-level reference model
// compared every cycle, directed literal cases, and a randomized phase.
module tb_ex_muldiv_unit;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] operand_top = 8'h00;
  logic [WIDTH-1:0] operand_bot = 8'h00;
  logic             flush = 1'b0;
  logic             stall_out;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  ex_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_top(operand_top), .operand_bot(operand_bot), .flush(flush),
    .stall_out(stall_out), .done(done), .result_hi(result_hi),
    .result_lo(result_lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a busy flag with a cycles-to-go count, results from plain * / %.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_left = 0;
  logic [7:0] m_hi = 8'h00, m_lo = 8'h00;
  bit         m_dz = 1'b0;
  logic [7:0] p_hi, p_lo;
  bit         p_dz;
  bit         was_idle;
  logic [15:0] prod;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      m_hi = 8'h00; m_lo = 8'h00; m_dz = 1'b0;
    end else begin
      was_idle = !m_busy && !m_done;
      m_done = 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1;
            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
          end
        end
      end else if (was_idle && start && !flush) begin
        if (op && operand_bot == 8'h00) begin
          m_done = 1'b1; m_hi = operand_top; m_lo = 8'hFF; m_dz = 1'b1;
        end else begin
          if (op) begin
            p_lo = operand_top / operand_bot;
            p_hi = operand_top % operand_bot;
          end else begin
            prod = 16'(operand_top) * 16'(operand_bot);
            p_hi = prod[15:8];
            p_lo = prod[7:0];
          end
          p_dz = 1'b0;
          m_busy = 1'b1;
          m_left = WIDTH;
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the inactive edge.
  always @(negedge clock) begin
    chk("done", done, m_done);
    chk("stall_out", stall_out, m_busy | (!m_busy && !m_done && start && !flush));
    chk("result_hi", result_hi, m_hi);
    chk("result_lo", result_lo, m_lo);
    chk("div_zero", div_zero, m_dz);
  end

  task automatic do_op(input string nm, input bit o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eh, input logic [7:0] el, input bit edz, input int lat);
    int  n;
    bit  got;
    @(posedge clock); #1;
    start = 1'b1; op = o; operand_top = a; operand_bot = b;
    #1 chk({nm, " start stall"}, stall_out, 1'b1);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      got = done;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " hi"}, result_hi, eh);
    chk({nm, " lo"}, result_lo, el);
    chk({nm, " div_zero"}, div_zero, edz);
  endtask

  initial begin
    int  n;
    bit  got;
    #1 reset = 1'b1;
    #2 chk("reset hi", result_hi, 8'h00);
    chk("reset lo", result_lo, 8'h00);
    chk("reset done", done, 1'b0);
    chk("reset stall", stall_out, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    do_op("mul 200*3", 1'b0, 8'hC8, 8'h03, 8'h02, 8'h58, 1'b0, 9);
    do_op("mul 255*255", 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 9);
    // Start raised during DONE is ignored; held into the next IDLE cycle it is accepted.
    start = 1'b1; op = 1'b0; operand_top = 8'h03; operand_bot = 8'h04;
    @(posedge clock); #1;
    chk("b2b idle done", done, 1'b0);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      got = done;
    end
    chk("b2b latency", n, 9);
    chk("b2b lo", result_lo, 8'h0C);
    chk("b2b hi", result_hi, 8'h00);

    do_op("div 200/7", 1'b1, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0, 9);
    do_op("div 0x55/0", 1'b1, 8'h55, 8'h00, 8'h55, 8'hFF, 1'b1, 1);
    chk("dbz stall in done", stall_out, 1'b0);
    do_op("div 200/7 again", 1'b1, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0, 9);

    // Flush in cycle T+4 of MUL 10*10.
    @(posedge clock); #1;
    start = 1'b1; op = 1'b0; operand_top = 8'h0A; operand_bot = 8'h0A;
    repeat (4) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    #1 chk("flush stall low", stall_out, 1'b0);
    got = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      got = got | done;
    end
    chk("flush no done", got, 1'b0);
    chk("flush keeps hi", result_hi, 8'h04);
    chk("flush keeps lo", result_lo, 8'h1C);
    start = 1'b1; flush = 1'b1;
    #1 chk("start+flush stall", stall_out, 1'b0);
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    #1 chk("start+flush idle stall", stall_out, 1'b0);
    got = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      got = got | done;
    end
    chk("start+flush no done", got, 1'b0);

    // Asynchronous reset in the middle of a run.
    @(posedge clock); #1;
    start = 1'b1; op = 1'b1; operand_top = 8'h64; operand_bot = 8'h03;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("async rst hi", result_hi, 8'h00);
    chk("async rst lo", result_lo, 8'h00);
    chk("async rst stall", stall_out, 1'b0);
    chk("async rst done", done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    got = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      got = got | done;
    end
    chk("aborted no done", got, 1'b0);
    do_op("div 9/2", 1'b1, 8'h09, 8'h02, 8'h01, 8'h04, 1'b0, 9);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      start       = ($urandom_range(0, 2) == 0);
      op          = $urandom_range(0, 1);
      operand_top = 8'($urandom_range(0, 255));
      operand_bot = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      flush       = ($urandom_range(0, 24) == 0);
    end
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
